// File: rtl/pwl_sched_pkg.sv
// Shared types for the PWL activation scheduler: FSM states, per-element tag, default latencies.
package pwl_sched_pkg;

  localparam int LOOKUP_LAT_DEF = 2;
  localparam int MAD_LAT_DEF    = 5;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  typedef struct packed {
    logic valid;
    logic last;
    logic id;
  } tag_t;

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pwl_tag_delay.sv
// Fixed-latency shift register; any_vld reports whether any stage holds a valid entry.
module pwl_tag_delay #(
  parameter int W       = 3,
  parameter int DEPTH   = 1,
  parameter int VLD_BIT = W - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         any_vld
);

  logic [DEPTH-1:0][W-1:0] stg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_vld = any_vld | stg[i][VLD_BIT];
  end

  assign dout = stg[DEPTH-1];

endmodule

// File: rtl/pwl_activation_scheduler.sv
// Round-robin burst scheduler sharing one PWL sigmoid lookup + multiply-add between two engines.
module pwl_activation_scheduler
  import pwl_sched_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int LOOKUP_LAT = LOOKUP_LAT_DEF,
  parameter int MAD_LAT    = MAD_LAT_DEF,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] cmp_x,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  output logic              mad_valid,
  output logic [DATA_W-1:0] mad_x,
  output logic [DATA_W-1:0] mad_a,
  output logic [DATA_W-1:0] mad_b,
  input  logic [DATA_W-1:0] mad_y,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic              out_last,
  output logic              busy
);

  state_e            state, state_nxt;
  logic              id_q, rr_q;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic              grant_id, start, accept, last_acc, drain_ok;
  logic [LEN_W-1:0]  grant_len;
  tag_t              cmp_tag, a_tag, mad_tag, y_tag, out_tag;
  logic [DATA_W-1:0] a_x;
  logic [DATA_W+2:0] d1_din, d1_dout;
  logic              a_busy, y_busy;

  assign grant_id  = req[rr_q] ? rr_q : ~rr_q;
  assign grant_len = grant_id ? len1 : len0;
  assign start     = (state == IDLE) && (|req);
  assign accept    = in_valid && in_ready;
  assign last_acc  = accept && (cnt_q == len_q - LEN_W'(1));
  // The burst retires once nothing is left ahead of the output register.
  assign drain_ok  = (state == DRAIN) && !cmp_tag.valid && !a_busy &&
                     !mad_tag.valid && !y_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (grant_len == '0) ? DRAIN : STREAM;
      STREAM:  if (last_acc) state_nxt = DRAIN;
      DRAIN:   if (drain_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt      = 2'b00;
    in_ready = 1'b0;
    busy     = (state != IDLE);
    if (state != IDLE)  gnt      = onehot(id_q);
    if (state == STREAM) in_ready = (cnt_q != len_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q  <= 1'b0;
      rr_q  <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      done  <= 2'b00;
    end else begin
      done <= drain_ok ? onehot(id_q) : 2'b00;
      if (start) begin
        id_q  <= grant_id;
        len_q <= grant_len;
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (drain_ok) rr_q <= ~id_q;
    end
  end

  // Stage 0: operand register feeding the lookup, with its tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_tag <= '0;
      cmp_x   <= '0;
    end else begin
      cmp_tag <= tag_t'{valid: accept, last: last_acc, id: id_q};
      if (accept) cmp_x <= in_data;
    end
  end

  assign d1_din       = {cmp_tag, cmp_x};
  assign {a_tag, a_x} = d1_dout;

  pwl_tag_delay #(.W(DATA_W + 3), .DEPTH(LOOKUP_LAT), .VLD_BIT(DATA_W + 2)) u_lookup_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (d1_din),
    .dout    (d1_dout),
    .any_vld (a_busy)
  );

  // x now lines up with the lookup's a/b; capture the multiply-add operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mad_tag <= '0;
      mad_x   <= '0;
      mad_a   <= '0;
      mad_b   <= '0;
    end else begin
      mad_tag <= a_tag;
      if (a_tag.valid) begin
        mad_x <= a_x;
        mad_a <= cmp_a;
        mad_b <= cmp_b;
      end
    end
  end

  pwl_tag_delay #(.W(3), .DEPTH(MAD_LAT), .VLD_BIT(2)) u_mad_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (mad_tag),
    .dout    (y_tag),
    .any_vld (y_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_tag  <= '0;
      out_data <= '0;
    end else begin
      out_tag <= y_tag;
      if (y_tag.valid) out_data <= mad_y;
    end
  end

  assign mad_valid = mad_tag.valid;
  assign out_valid = out_tag.valid;
  assign out_id    = out_tag.id;
  assign out_last  = out_tag.last;

endmodule

// File: tb/tb_pwl_activation_scheduler.sv
// Scoreboard bench: models the external lookup/multiply-add, drives randomized bursts, checks results.
module tb_pwl_activation_scheduler;

  localparam int LEN_W = 8;
  localparam int LL    = 2;
  localparam int ML    = 5;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic [1:0]       gnt, done;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             in_ready;
  logic [DW-1:0]    cmp_x, cmp_a, cmp_b, mad_x, mad_a, mad_b, mad_y, out_data;
  logic             mad_valid, out_valid, out_id, out_last, busy;

  always #5 clk = ~clk;

  pwl_activation_scheduler #(.LEN_W(LEN_W), .LOOKUP_LAT(LL), .MAD_LAT(ML), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .len0(len0), .len1(len1), .gnt(gnt), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmp_x(cmp_x), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .mad_valid(mad_valid), .mad_x(mad_x), .mad_a(mad_a), .mad_b(mad_b), .mad_y(mad_y),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  // Stand-ins for the external segment lookup and multiply-add, with their latencies.
  function automatic logic [DW-1:0] seg_a(input logic [DW-1:0] x);
    return x ^ 32'h3c00_1234;
  endfunction
  function automatic logic [DW-1:0] seg_b(input logic [DW-1:0] x);
    return {x[15:0], x[31:16]};
  endfunction

  logic [DW-1:0] xh [LL];
  logic [DW-1:0] mh [ML];
  always @(posedge clk) begin
    xh[0] <= cmp_x;
    for (int i = 1; i < LL; i++) xh[i] <= xh[i-1];
    mh[0] <= mad_x * mad_a + mad_b;
    for (int i = 1; i < ML; i++) mh[i] <= mh[i-1];
  end
  assign cmp_a = seg_a(xh[LL-1]);
  assign cmp_b = seg_b(xh[LL-1]);
  assign mad_y = mh[ML-1];

  typedef struct { logic [DW-1:0] y; logic id; logic last; int cyc; } exp_t;
  typedef struct { logic id; logic had_out; } dexp_t;

  exp_t          sb[$];
  dexp_t         dq[$];
  logic [DW-1:0] xq[$];
  exp_t          mon_e;
  dexp_t         mon_d;
  int checks = 0, errors = 0, cyc = 0, last_out_cyc = -100, turn = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every result and every done pulse is matched against what the driver queued.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got out_valid id=%0d data=0x%0h, expected none (cycle %0d)",
                   out_id, out_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e.y));
          chk("out_id", 64'(out_id), 64'(mon_e.id));
          chk("out_last", 64'(out_last), 64'(mon_e.last));
          chk("out_cycle", 64'(cyc), 64'(mon_e.cyc));
          if (out_last) last_out_cyc = cyc;
        end
      end
      if (done != 2'b00) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=%b, expected none (cycle %0d)", done, cyc);
        end else begin
          mon_d = dq.pop_front();
          chk("done_id", 64'(done), mon_d.id ? 64'd2 : 64'd1);
          chk("gnt_at_done", 64'(gnt), 64'd0);
          if (mon_d.had_out) chk("done_timing", 64'(cyc), 64'(last_out_cyc + 1));
        end
      end
    end
  end

  // Waits for the grant, streams the burst (gap<0: random idle cycles), waits for done.
  task automatic serve(input int exp_id, input int gap);
    int w, id, L, n, gapc;
    logic acc;
    logic [DW-1:0] x;
    w = 0;
    while (gnt == 2'b00 && w < 40) begin @(negedge clk); w++; end
    chk("grant", 64'(gnt), exp_id != 0 ? 64'd2 : 64'd1);
    if (gnt == 2'b00) return;
    chk("busy", 64'(busy), 64'd1);
    id = exp_id;
    L  = (id != 0) ? int'(len1) : int'(len0);
    req[id] = 1'b0;
    dq.push_back(dexp_t'{id[0], L > 0});
    n = 0; gapc = 0; acc = 1'b0; w = 0; x = '0;
    while (n < L && w < 4 * L + 50) begin
      in_valid = 1'b0;
      if (gapc > 0) begin
        gapc--;
      end else if (in_ready) begin
        if (xq.size() > 0) x = xq.pop_front();
        else               x = $urandom;
        in_valid = 1'b1;
        in_data  = x;
        sb.push_back(exp_t'{x * seg_a(x) + seg_b(x), id[0], n == L - 1, cyc + LL + ML + 3});
        n++;
        gapc = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        acc  = 1'b1;
      end
      @(negedge clk); w++;
      if (acc) begin chk("cmp_x", 64'(cmp_x), 64'(x)); acc = 1'b0; end
    end
    in_valid = 1'b0;
    if (n < L) begin
      checks++; errors++;
      $display("FAIL stream_timeout: got %0d accepts, expected %0d", n, L);
    end
    if (L > 0) chk("ready_drop", 64'(in_ready), 64'd0);
    w = 0;
    while (done == 2'b00 && w < 100) begin @(negedge clk); w++; end
    chk("done_seen", 64'(done != 2'b00), 64'd1);
    turn = 1 - exp_id;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_ready_done_busy"}, 64'({in_ready, done, busy}), 64'd0);
    chk({tag, "_cmp_x"}, 64'(cmp_x), 64'd0);
    chk({tag, "_mad"}, 64'(mad_valid) | 64'(mad_x) | 64'(mad_a) | 64'(mad_b), 64'd0);
    chk({tag, "_out"}, 64'({out_valid, out_id, out_last}) | 64'(out_data), 64'd0);
  endtask

  task automatic reset_mid_drain();
    int w, n;
    len1 = 8'd4;
    req  = 2'b10;
    w = 0;
    while (gnt == 2'b00 && w < 40) begin @(negedge clk); w++; end
    chk("grant_pre_reset", 64'(gnt), 64'd2);
    req = 2'b00;
    n = 0; w = 0;
    while (n < 4 && w < 40) begin
      in_valid = in_ready;
      if (in_ready) begin in_data = $urandom; n++; end
      @(negedge clk); w++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("busy_in_drain", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    turn = 0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Both request after reset: 0 first, then 1, then 0 again.
    len0 = LEN_W'($urandom_range(1, 6)); len1 = LEN_W'($urandom_range(1, 6));
    req = 2'b11;
    serve(0, -1);
    serve(1, -1);
    req = 2'b11;
    serve(0, -1);
    serve(1, -1);

    // Directed three-element burst: 1.0, -2.5, 6.0.
    xq.push_back(32'h3F80_0000); xq.push_back(32'hC020_0000); xq.push_back(32'h40C0_0000);
    len0 = 8'd3; req = 2'b01;
    serve(0, 0);

    // Zero-length burst on requester 1.
    len1 = 8'd0; req = 2'b10;
    serve(1, 0);

    // Two elements with two idle cycles between them.
    len0 = 8'd2; req = 2'b01;
    serve(0, 2);

    for (int k = 0; k < 6; k++) begin
      int r, first;
      r     = int'($urandom_range(1, 3));
      len0  = LEN_W'($urandom_range(1, 24));
      len1  = LEN_W'($urandom_range(1, 24));
      first = (r == 3) ? turn : ((r == 2) ? 1 : 0);
      req   = 2'(r);
      serve(first, -1);
      if (r == 3) serve(1 - first, -1);
    end

    // Maximum burst; leaves the round-robin pointer on requester 1.
    len0 = 8'd255; req = 2'b01;
    serve(0, 0);

    reset_mid_drain();
    len0 = LEN_W'($urandom_range(1, 5)); len1 = LEN_W'($urandom_range(1, 5));
    req = 2'b11;
    serve(0, -1);
    serve(1, -1);

    repeat (15) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("done_queue_empty", 64'(dq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
